// File: rtl/button_event_arbiter.sv
// ---------------------------------------------------------------------------
// button_event_arbiter
//
// Turns four debounced, active-low buttons into a queue of press events.
// Each button has a small state machine. It classifies a press as short
// (released before the hold threshold) or long (still held LONG_COUNT edges
// after the press edge). A round-robin arbiter moves at most one pending
// request per cycle into a FIFO. The consumer drains the FIFO with a
// valid/ready handshake.
//
// Parameters
//   LONG_COUNT  hold length in edges after the press edge that makes a long press (>= 2)
//   FIFO_DEPTH  event queue depth (power of two)
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   bot_in     debounced buttons, active-low (1 = released)
//   ev_ready   consumer accepts the head event this cycle
//   ev_valid   queue not empty; head event presented
//   ev_id      button index of the head event
//   ev_long    head event type: 1 = long press, 0 = short press
//   fifo_full  queue holds FIFO_DEPTH events
//   overflow   sticky: a request was dropped because its button was still pending
// ---------------------------------------------------------------------------
module button_event_arbiter #(
    parameter int LONG_COUNT = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bot_in,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [1:0] ev_id,
    output logic       ev_long,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int CNT_W  = $clog2(LONG_COUNT + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HELD      = 2'd1,
        ST_LONG_DONE = 2'd2
    } btn_state_e;

    typedef struct packed {
        logic [1:0] id;
        logic       is_long;
    } event_t;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [3:0] bot_q;
    logic [3:0] press_edge;
    logic [3:0] release_edge;

    assign press_edge   = ~bot_in & bot_q;
    assign release_edge = bot_in & ~bot_q;

    // ------------------------------------------------------------------
    // Per-button press classifier (two-process FSM)
    // ------------------------------------------------------------------
    btn_state_e       state_q [4];
    btn_state_e       state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       req;
    logic [3:0]       req_long;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        req      = '0;
        req_long = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (press_edge[i]) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = '0;
                    end
                end
                ST_HELD: begin
                    // In HELD the previous sample was low, so a high input is
                    // always a release edge. A release on the threshold edge
                    // itself therefore still counts as a short press.
                    if (release_edge[i]) begin
                        req[i]     = 1'b1;
                        state_d[i] = ST_IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        if (cnt_q[i] == LONG_LAST) begin
                            req[i]      = 1'b1;
                            req_long[i] = 1'b1;
                            state_d[i]  = ST_LONG_DONE;
                        end
                    end
                end
                ST_LONG_DONE: begin
                    cnt_d[i] = cnt_q[i];
                    if (release_edge[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, whatever order the blocks execute in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bot_q <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            bot_q <= bot_in;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending requests and round-robin arbiter
    // ------------------------------------------------------------------
    logic [3:0] pending_q;
    logic [3:0] pending_d;
    logic [3:0] pend_long_q;
    logic [3:0] pend_long_d;
    logic       overflow_q;
    logic       overflow_d;
    logic [1:0] rr_ptr_q;
    logic [1:0] rr_ptr_d;
    logic       grant_found;
    logic [1:0] grant_idx;
    logic       push;
    logic       pop;
    logic       room;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!grant_found && pending_q[rr_ptr_q + 2'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_ptr_q + 2'(k);
            end
        end
    end

    // A full queue still has room this cycle if the head is being popped.
    assign room = !fifo_full || pop;
    assign push = grant_found && room;

    always_comb begin
        pending_d   = pending_q;
        pend_long_d = pend_long_q;
        overflow_d  = overflow_q;
        rr_ptr_d    = rr_ptr_q;
        if (push) begin
            pending_d[grant_idx] = 1'b0;
            rr_ptr_d             = grant_idx + 2'd1;
        end
        // Collisions are judged against the registered pending bit: a
        // request whose button is still pending is dropped, even when that
        // button is granted on this same edge.
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                if (pending_q[i]) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d[i]   = 1'b1;
                    pend_long_d[i] = req_long[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            pend_long_q <= '0;
            overflow_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            pend_long_q <= pend_long_d;
            overflow_q  <= overflow_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    event_t            mem_q [FIFO_DEPTH];
    event_t            push_entry;
    event_t            head;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FCNT_W-1:0] count_q;
    logic [FCNT_W-1:0] count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_entry = '{id: grant_idx, is_long: pend_long_q[grant_idx]};
    assign pop        = ev_valid && ev_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // NOTE: the storage array has no reset. Outputs are gated by the count,
    // which does reset, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign ev_valid  = (count_q != '0);
    assign ev_id     = ev_valid ? head.id : 2'd0;
    assign ev_long   = ev_valid ? head.is_long : 1'b0;
    assign fifo_full = (count_q == FCNT_W'(FIFO_DEPTH));
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_button_event_arbiter
//
// Directed scenarios followed by randomized button activity. Each cycle is
// checked against a behavioural model. The model tracks each button by the
// edge number of its press. It keeps a pending bit per button, a round-robin
// index and a queue of events.
// ---------------------------------------------------------------------------
module tb_button_event_arbiter;

    localparam int LC = 10;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] bot_in = 4'hF;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       ev_long;
    logic       fifo_full;
    logic       overflow;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .LONG_COUNT(LC),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bot_in   (bot_in),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_id    (ev_id),
        .ev_long  (ev_long),
        .fifo_full(fifo_full),
        .overflow (overflow)
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    bit         m_track  [4];
    int         m_tpress [4];
    bit         m_fired  [4];
    bit   [3:0] m_prev;
    bit   [3:0] m_pend;
    bit   [3:0] m_plong;
    bit         m_ovf;
    int         m_rr;
    logic [2:0] m_q[$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_track[i]  = 1'b0;
            m_tpress[i] = 0;
            m_fired[i]  = 1'b0;
        end
        m_prev  = 4'hF;
        m_pend  = '0;
        m_plong = '0;
        m_ovf   = 1'b0;
        m_rr    = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input logic [3:0] b, input logic r);
        bit [3:0] pend_old;
        bit       do_pop;
        bit       has_room;
        int       g;
        bit       raise;
        bit       lng;
        pend_old = m_pend;
        do_pop   = (m_q.size() > 0) && r;
        has_room = (m_q.size() < FD) || do_pop;
        if (do_pop) void'(m_q.pop_front());
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && pend_old[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        end
        if (g >= 0 && has_room) begin
            m_q.push_back({g[1:0], m_plong[g]});
            m_pend[g] = 1'b0;
            m_rr      = (g + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
            raise = 1'b0;
            lng   = 1'b0;
            if (!m_track[i]) begin
                if (m_prev[i] && !b[i]) begin
                    m_track[i]  = 1'b1;
                    m_tpress[i] = cyc;
                    m_fired[i]  = 1'b0;
                end
            end else if (b[i]) begin
                if (!m_fired[i]) raise = 1'b1;
                m_track[i] = 1'b0;
            end else if (!m_fired[i] && (cyc - m_tpress[i]) == LC) begin
                raise      = 1'b1;
                lng        = 1'b1;
                m_fired[i] = 1'b1;
            end
            if (raise) begin
                if (pend_old[i]) begin
                    m_ovf = 1'b1;
                end else begin
                    m_pend[i]  = 1'b1;
                    m_plong[i] = lng;
                end
            end
            m_prev[i] = b[i];
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        check("ev_valid", 8'(ev_valid), 8'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("ev_id", 8'(ev_id), 8'(m_q[0][2:1]));
            check("ev_long", 8'(ev_long), 8'(m_q[0][0]));
        end
        check("fifo_full", 8'(fifo_full), 8'(m_q.size() == FD));
        check("overflow", 8'(overflow), 8'(m_ovf));
    endtask

    // Inputs change just after a falling edge; outputs are sampled on the
    // next falling edge.
    task automatic step(input logic [3:0] b, input logic r);
        bot_in   = b;
        ev_ready = r;
        @(posedge clk);
        cyc++;
        model_edge(b, r);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic tap(input int btn, input int low_n, input int high_n, input logic r);
        logic [3:0] b;
        b      = 4'hF;
        b[btn] = 1'b0;
        for (int k = 0; k < low_n; k++) step(b, r);
        for (int k = 0; k < high_n; k++) step(4'hF, r);
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input logic [3:0] b_during);
        #2;
        reset = 1'b0;
        #1;
        check("rst_valid", 8'(ev_valid), 8'h0);
        check("rst_id", 8'(ev_id), 8'h0);
        check("rst_long", 8'(ev_long), 8'h0);
        check("rst_full", 8'(fifo_full), 8'h0);
        check("rst_ovf", 8'(overflow), 8'h0);
        model_reset();
        bot_in = b_during;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int         dur [4];
        logic [3:0] b_r;
        logic       rdy;
        int         rdy_mode;

        model_reset();
        #2;
        reset = 1'b0;
        #1;
        check("init_valid", 8'(ev_valid), 8'h0);
        check("init_id", 8'(ev_id), 8'h0);
        check("init_long", 8'(ev_long), 8'h0);
        check("init_full", 8'(fifo_full), 8'h0);
        check("init_ovf", 8'(overflow), 8'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(4'hF, 1'b1);

        // Short press on button 2: low for 3 edges, then released.
        tap(2, 3, 1, 1'b1);
        check("short_before", 8'(ev_valid), 8'h0);
        step(4'hF, 1'b1);
        check("short_valid", 8'(ev_valid), 8'h1);
        check("short_id", 8'(ev_id), 8'h2);
        check("short_long", 8'(ev_long), 8'h0);
        step(4'hF, 1'b1);
        check("short_once", 8'(ev_valid), 8'h0);

        // Long press on button 0 held 30 edges.
        for (int k = 1; k <= 30; k++) begin
            step(4'b1110, 1'b1);
            if (k == LC + 2) begin
                check("long_valid", 8'(ev_valid), 8'h1);
                check("long_id", 8'(ev_id), 8'h0);
                check("long_type", 8'(ev_long), 8'h1);
            end
        end
        for (int k = 0; k < 4; k++) step(4'hF, 1'b1);
        check("long_no_release_ev", 8'(ev_valid), 8'h0);

        // Boundary: release on the threshold edge is short; one later is long only.
        tap(3, LC, 1, 1'b1);
        step(4'hF, 1'b1);
        check("bound_valid", 8'(ev_valid), 8'h1);
        check("bound_short", 8'(ev_long), 8'h0);
        step(4'hF, 1'b1);
        tap(3, LC + 1, 5, 1'b1);

        // Buttons 0, 1, 3 released together; round-robin from 0.
        for (int k = 0; k < 3; k++) step(4'b0100, 1'b1);
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);
        check("sim_id0", 8'(ev_id), 8'h0);
        step(4'hF, 1'b1);
        check("sim_id1", 8'(ev_id), 8'h1);
        step(4'hF, 1'b1);
        check("sim_id3", 8'(ev_id), 8'h3);
        step(4'hF, 1'b1);

        // Backpressure: six short presses with ev_ready low, then a repeat.
        tap(0, 2, 2, 1'b0);
        tap(1, 2, 2, 1'b0);
        tap(2, 2, 2, 1'b0);
        tap(3, 2, 2, 1'b0);
        check("bp_full", 8'(fifo_full), 8'h1);
        tap(0, 2, 2, 1'b0);
        tap(1, 2, 2, 1'b0);
        check("bp_no_ovf", 8'(overflow), 8'h0);
        tap(0, 2, 2, 1'b0);
        check("bp_ovf", 8'(overflow), 8'h1);
        for (int k = 0; k < 12; k++) step(4'hF, 1'b1);

        // Reset during a long hold with two queued events.
        tap(2, 2, 2, 1'b0);
        tap(3, 2, 2, 1'b0);
        for (int k = 0; k < 5; k++) step(4'b1110, 1'b0);
        do_reset(4'hF);
        for (int k = 0; k < 15; k++) step(4'hF, 1'b1);
        check("post_rst_quiet", 8'(ev_valid), 8'h0);

        // Button held through reset release is seen as a fresh press.
        step(4'b1101, 1'b1);
        do_reset(4'b1101);
        for (int k = 0; k < 3; k++) step(4'b1101, 1'b1);
        step(4'hF, 1'b1);
        step(4'hF, 1'b0);
        check("held_rst_valid", 8'(ev_valid), 8'h1);
        check("held_rst_id", 8'(ev_id), 8'h1);
        step(4'hF, 1'b1);

        // Randomized activity with durations straddling the long threshold.
        b_r = 4'hF;
        for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 14);
        rdy_mode = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) rdy_mode = $urandom_range(0, 2);
            for (int i = 0; i < 4; i++) begin
                if (dur[i] == 0) begin
                    b_r[i] = ~b_r[i];
                    dur[i] = $urandom_range(1, 14);
                end else begin
                    dur[i]--;
                end
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = ($urandom_range(0, 3) == 0);
            endcase
            step(b_r, rdy);
            if (n % 1300 == 1299) do_reset(b_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter LONG_COUNT, default 10 (synthesis value 25000000): held cycles after a press edge at which a long-press event is raised; legal range >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event queue depth, power of two.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port bot_in  input  4  debounced buttons from the debounce blocks, active-low (1 = released).
REQ-006 SHALL have port ev_ready  input  1  consumer (mode state machine) accepts the head event this cycle.
REQ-007 SHALL have port ev_valid  output  1  queue not empty; head event presented.
REQ-008 SHALL have port ev_id  output  2  button index of the head event.
REQ-009 SHALL have port ev_long  output  1  head event type: 1 = long press, 0 = short press.
REQ-010 SHALL have port fifo_full  output  1  queue holds FIFO_DEPTH events.
REQ-011 SHALL have port overflow  output  1  sticky flag: an event was lost.

Function
REQ-012 SHALL register bot_in into bot_q each edge; press edge on button i = bot_in[i]==0 && bot_q[i]==1; release edge = bot_in[i]==1 && bot_q[i]==0.
REQ-013 SHALL run per-button FSM with states IDLE, HELD, LONG_DONE and a hold counter of width $clog2(LONG_COUNT+1).
REQ-014 IDLE: on press edge -> HELD, counter <= 0.
REQ-015 HELD: while bot_in[i]==0, counter increments; on the edge where counter==LONG_COUNT-1, raise long request and go to LONG_DONE.
REQ-016 HELD: on release edge, raise short request and go to IDLE; a release at exactly LONG_COUNT cycles after the press edge is short.
REQ-017 LONG_DONE: counter holds; on release edge go to IDLE with no event.
REQ-018 A raised request SHALL set pending[i] and pend_long[i] on the same edge.
REQ-019 If a request is raised while pending[i] is already 1, the new request SHALL be dropped, the old one kept, and overflow set.
REQ-020 Arbiter SHALL grant at most one pending button per cycle, round-robin starting at rr_ptr; after a grant, rr_ptr <= granted index + 1 (mod 4).
REQ-021 Grant SHALL occur only if the queue has room: count < FIFO_DEPTH, or count == FIFO_DEPTH with ev_ready && ev_valid the same cycle.
REQ-022 On grant, the {index, pend_long} entry SHALL be pushed and pending cleared on the same edge; ungranted requests stay pending with no loss (backpressure).
REQ-023 Queue SHALL be FIFO-ordered; ev_valid, ev_id, ev_long SHALL be driven combinationally from the head; pop when ev_valid && ev_ready.
REQ-024 ev_ready while ev_valid==0 SHALL have no effect.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 Latency: request raised at edge k -> pushed at edge k+1 (if granted) -> ev_valid high after edge k+1.
REQ-027 overflow SHALL clear only on reset.

Reset
REQ-028 reset==0 SHALL asynchronously force: all FSMs IDLE, counters 0, bot_q = 4'b1111, pending = 0, rr_ptr = 0, queue empty, ev_valid = 0, ev_id = 0, ev_long = 0, fifo_full = 0, overflow = 0.
REQ-029 On reset deassertion with a button held, the first edge SHALL see a press edge for that button.
REQ-030 Reset mid-hold or with a non-empty queue SHALL discard all state; no event is emitted for presses begun before reset.

Verification (LONG_COUNT=10, FIFO_DEPTH=4)
REQ-031 Short press: bot_in[2] low for 3 cycles, then high, ev_ready=1 -> exactly one event id=2, long=0; ev_valid high for 1 cycle starting 1 cycle after the release edge.
REQ-032 Long press: bot_in[0] held 30 cycles -> one event id=0, long=1 after 10 held cycles; no event on release.
REQ-033 Boundary: release exactly 10 cycles after the press edge -> short event; release at 11 -> long only.
REQ-034 Simultaneous: buttons 0,1,3 released on the same edge, rr_ptr=0 -> events id 0, 1, 3 on consecutive cycles; then button 0 again with 1 still pending -> order follows rr_ptr.
REQ-035 Backpressure: ev_ready=0, 6 short presses on distinct presses -> fifo_full=1 after 4; remaining requests stay pending; overflow=1 only when a button re-requests while pending; ev_ready=1 drains in order.
REQ-036 Reset asserted mid long-hold with 2 queued events -> all outputs at reset values immediately (asynchronously); no event emitted afterwards until a new press.
